// File: rtl/twiddle_gen.sv
// Table-free FP4 twiddle generator for a radix-2 FFT: random-access lookups plus a
// per-stage sequencer, through a two-stage pipeline with a valid/ready output.
module twiddle_gen #(
    parameter int MAX_N      = 32,
    parameter int ADDR_WIDTH = $clog2(MAX_N),
    parameter int LOG2W      = $clog2(ADDR_WIDTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [LOG2W-1:0]      cfg_log2n,
    input  logic                  cfg_inverse,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ADDR_WIDTH-1:0] req_k,
    input  logic                  seq_start,
    input  logic [LOG2W-1:0]      seq_stage,
    output logic                  seq_busy,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [7:0]            twiddle_out,
    output logic [ADDR_WIDTH-1:0] out_k,
    output logic                  out_last,
    output logic                  cfg_err
);

    localparam int unsigned      QTR  = MAX_N / 4;
    localparam logic [LOG2W-1:0] AW_L = LOG2W'(ADDR_WIDTH);

    typedef enum logic {IDLE, SEQ} state_t;

    state_t                state_q;
    logic [LOG2W-1:0]      seq_n_q;
    logic [LOG2W-1:0]      seq_s_q;
    logic                  seq_inv_q;
    logic [ADDR_WIDTH-1:0] j_q;

    logic                  s1_valid_q;
    logic                  s1_zero_q;
    logic                  s1_inv_q;
    logic                  s1_last_q;
    logic [ADDR_WIDTH-1:0] s1_a_q;
    logic [ADDR_WIDTH-1:0] s1_k_q;

    logic                  out_valid_q;
    logic                  out_last_q;
    logic                  cfg_err_q;
    logic [7:0]            twiddle_q;
    logic [ADDR_WIDTH-1:0] out_k_q;

    logic                  adv;
    logic                  req_fire;
    logic                  n_ok;
    logic                  stage_ok;
    logic                  seq_last;
    logic [ADDR_WIDTH-1:0] seq_k;
    logic [ADDR_WIDTH-1:0] seq_a;
    logic [ADDR_WIDTH-1:0] req_a;

    logic [1:0]            quad;
    int unsigned           r;
    int unsigned           q_re;
    int unsigned           q_im;
    logic                  neg_re;
    logic                  neg_im;
    logic [7:0]            tw_d;

    // Integer thresholds stand in for cos(q*pi/(2Q)) crossing 0.75 and 0.25.
    function automatic logic [2:0] quant(input int unsigned q);
        if (1000 * q < 460 * QTR) begin
            quant = 3'b010;
        end else if (1000 * q < 839 * QTR) begin
            quant = 3'b001;
        end else begin
            quant = 3'b000;
        end
    endfunction

    function automatic logic [3:0] fp4(input logic neg, input logic [2:0] m);
        fp4 = (m == 3'b000) ? 4'b0000 : {neg, m};
    endfunction

    always_comb begin
        adv       = !out_valid_q || out_ready;
        req_ready = adv && (state_q == IDLE) && !seq_start;
        req_fire  = req_valid && req_ready;
        n_ok      = (cfg_log2n != '0) && (cfg_log2n <= AW_L);
        stage_ok  = seq_stage < cfg_log2n;
        seq_k     = j_q << (seq_n_q - seq_s_q - LOG2W'(1));
        seq_a     = seq_k << (AW_L - seq_n_q);
        req_a     = n_ok ? (req_k << (AW_L - cfg_log2n)) : '0;
        seq_last  = (j_q == ADDR_WIDTH'((32'd1 << seq_s_q) - 32'd1));
    end

    // Quarter-wave fold: odd quadrants swap which axis distance feeds real vs imag.
    always_comb begin
        quad   = s1_a_q[ADDR_WIDTH-1 -: 2];
        r      = 32'(s1_a_q) % QTR;
        q_re   = quad[0] ? (QTR - r) : r;
        q_im   = quad[0] ? r : (QTR - r);
        neg_re = (quad == 2'd1) || (quad == 2'd2);
        neg_im = !quad[1] ^ s1_inv_q;
        tw_d   = s1_zero_q ? 8'h00 : {fp4(neg_re, quant(q_re)), fp4(neg_im, quant(q_im))};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            seq_n_q     <= '0;
            seq_s_q     <= '0;
            seq_inv_q   <= 1'b0;
            j_q         <= '0;
            s1_valid_q  <= 1'b0;
            s1_zero_q   <= 1'b0;
            s1_inv_q    <= 1'b0;
            s1_last_q   <= 1'b0;
            s1_a_q      <= '0;
            s1_k_q      <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            cfg_err_q   <= 1'b0;
            twiddle_q   <= '0;
            out_k_q     <= '0;
        end else begin
            cfg_err_q <= req_fire && !n_ok;
            case (state_q)
                IDLE: begin
                    if (seq_start) begin
                        if (n_ok && stage_ok) begin
                            seq_n_q   <= cfg_log2n;
                            seq_s_q   <= seq_stage;
                            seq_inv_q <= cfg_inverse;
                            j_q       <= '0;
                            state_q   <= SEQ;
                        end else begin
                            cfg_err_q <= 1'b1;
                        end
                    end
                end
                SEQ: begin
                    if (adv) begin
                        if (seq_last) begin
                            j_q     <= '0;
                            state_q <= IDLE;
                        end else begin
                            j_q <= j_q + 1'b1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase

            // Both stages move together so a stalled output never loses S1 contents.
            if (adv) begin
                s1_valid_q <= req_fire || (state_q == SEQ);
                if (state_q == SEQ) begin
                    s1_a_q    <= seq_a;
                    s1_k_q    <= seq_k;
                    s1_inv_q  <= seq_inv_q;
                    s1_zero_q <= 1'b0;
                    s1_last_q <= seq_last;
                end else if (req_fire) begin
                    s1_a_q    <= req_a;
                    s1_k_q    <= req_k;
                    s1_inv_q  <= cfg_inverse;
                    s1_zero_q <= !n_ok;
                    s1_last_q <= 1'b0;
                end
                out_valid_q <= s1_valid_q;
                if (s1_valid_q) begin
                    twiddle_q  <= tw_d;
                    out_k_q    <= s1_k_q;
                    out_last_q <= s1_last_q;
                end
            end
        end
    end

    assign seq_busy    = (state_q == SEQ);
    assign out_valid   = out_valid_q;
    assign twiddle_out = twiddle_q;
    assign out_k       = out_k_q;
    assign out_last    = out_last_q;
    assign cfg_err     = cfg_err_q;

endmodule

// File: tb/tb_twiddle_gen.sv
// Bench for twiddle_gen (MAX_N=32): directed scenarios plus randomized traffic
// scored against a trigonometric-distance reference model.
module tb_twiddle_gen;

    localparam int MAX_N = 32;
    localparam int AW    = 5;
    localparam int LW    = 3;
    localparam int QTR   = MAX_N / 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [LW-1:0] cfg_log2n;
    logic          cfg_inverse;
    logic          req_valid;
    logic          req_ready;
    logic [AW-1:0] req_k;
    logic          seq_start;
    logic [LW-1:0] seq_stage;
    logic          seq_busy;
    logic          out_valid;
    logic          out_ready;
    logic [7:0]    twiddle_out;
    logic [AW-1:0] out_k;
    logic          out_last;
    logic          cfg_err;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [7:0]    tw;
        logic [AW-1:0] k;
        logic          last;
    } exp_t;

    always #5 clk = ~clk;

    twiddle_gen #(.MAX_N(MAX_N)) dut (
        .clk(clk), .rst(rst), .cfg_log2n(cfg_log2n), .cfg_inverse(cfg_inverse),
        .req_valid(req_valid), .req_ready(req_ready), .req_k(req_k),
        .seq_start(seq_start), .seq_stage(seq_stage), .seq_busy(seq_busy),
        .out_valid(out_valid), .out_ready(out_ready), .twiddle_out(twiddle_out),
        .out_k(out_k), .out_last(out_last), .cfg_err(cfg_err)
    );

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // |cos| or |sin| quantised from distance (in angle units) to the nearest peak axis.
    function automatic int quant_m(input int d);
        if (1000 * d < 460 * QTR) return 2;
        if (1000 * d < 839 * QTR) return 1;
        return 0;
    endfunction

    function automatic logic [3:0] nib(input bit neg, input int m);
        if (m == 0) return 4'h0;
        return {neg, 3'(m)};
    endfunction

    // W_N^k = cos(2*pi*a/MAX_N) - j*sin(2*pi*a/MAX_N); inverse conjugates.
    function automatic logic [7:0] model_tw(input int k, input int n, input bit inv);
        int nn, a, d_re, e, d_im;
        bit neg_re, neg_im;
        if (n < 1 || n > AW) return 8'h00;
        nn     = 1 << n;
        a      = (k % nn) * (MAX_N / nn);
        d_re   = a % (2 * QTR);
        d_re   = (d_re < 2 * QTR - d_re) ? d_re : 2 * QTR - d_re;
        e      = (a + QTR) % (2 * QTR);
        d_im   = (e < 2 * QTR - e) ? e : 2 * QTR - e;
        neg_re = (a > QTR) && (a < 3 * QTR);
        neg_im = ((a > 0) && (a < 2 * QTR)) ^ inv;
        return {nib(neg_re, quant_m(d_re)), nib(neg_im, quant_m(d_im))};
    endfunction

    task automatic do_req(input int k, input int n, input bit inv,
                          output logic v, output logic [7:0] tw, output logic err);
        req_k       = AW'(k);
        cfg_log2n   = LW'(n);
        cfg_inverse = inv;
        req_valid   = 1'b1;
        out_ready   = 1'b1;
        step();
        req_valid = 1'b0;
        err       = cfg_err;
        step();
        v  = out_valid;
        tw = twiddle_out;
    endtask

    task automatic test_reset();
        rst = 1'b1; cfg_log2n = '0; cfg_inverse = 1'b0; req_valid = 1'b0; req_k = '0;
        seq_start = 1'b0; seq_stage = '0; out_ready = 1'b0;
        step(); step();
        total++;
        if ({out_valid, seq_busy, twiddle_out, out_k, out_last, cfg_err} !== '0) begin
            bad++;
            $display("FAIL reset_state got v=%b busy=%b tw=%h k=%0d last=%b err=%b want all 0",
                     out_valid, seq_busy, twiddle_out, out_k, out_last, cfg_err);
        end
        rst = 1'b0; out_ready = 1'b1;
        #1;
        total++;
        if (req_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_ready got %b want 1", req_ready);
        end
        step();
    endtask

    task automatic test_back_to_back();
        int ks[5]  = '{0, 4, 8, 12, 16};
        logic [7:0] ex[5] = '{8'h20, 8'h19, 8'h0A, 8'h99, 8'hA0};
        cfg_log2n = 3'd5; cfg_inverse = 1'b0; out_ready = 1'b1;
        for (int c = 0; c < 7; c++) begin
            req_valid = (c < 5);
            req_k     = (c < 5) ? AW'(ks[c]) : '0;
            #1;
            if (c < 5) begin
                total++;
                if (req_ready !== 1'b1) begin
                    bad++;
                    $display("FAIL b2b_ready c=%0d got %b want 1", c, req_ready);
                end
            end
            step();
            total++;
            if (c >= 1 && c <= 5) begin
                if (out_valid !== 1'b1 || twiddle_out !== ex[c-1] || out_k !== AW'(ks[c-1])) begin
                    bad++;
                    $display("FAIL b2b_out c=%0d got v=%b tw=%h k=%0d want v=1 tw=%h k=%0d",
                             c, out_valid, twiddle_out, out_k, ex[c-1], ks[c-1]);
                end
            end else if (out_valid !== 1'b0) begin
                bad++;
                $display("FAIL b2b_idle c=%0d got v=%b want 0", c, out_valid);
            end
        end
        req_valid = 1'b0;
    endtask

    task automatic test_small_n();
        logic v, e;
        logic [7:0] tw;
        do_req(1, 3, 1'b0, v, tw, e);
        total++;
        if (v !== 1'b1 || tw !== 8'h19) begin
            bad++; $display("FAIL n3_k1 got v=%b tw=%h want v=1 tw=19", v, tw);
        end
        do_req(1, 3, 1'b1, v, tw, e);
        total++;
        if (v !== 1'b1 || tw !== 8'h11) begin
            bad++; $display("FAIL n3_k1_inv got v=%b tw=%h want v=1 tw=11", v, tw);
        end
        do_req(9, 3, 1'b0, v, tw, e);
        total++;
        if (v !== 1'b1 || tw !== 8'h19) begin
            bad++; $display("FAIL n3_k9_wrap got v=%b tw=%h want v=1 tw=19", v, tw);
        end
        step();
    endtask

    task automatic test_sequence(input bit stall);
        logic [7:0]    ex[4] = '{8'h20, 8'h19, 8'h0A, 8'h99};
        int            got = 0, busy = 0, hold = 0;
        bit            seen = 0;
        logic [7:0]    h_tw;
        logic [AW-1:0] h_k;
        logic          h_last;
        cfg_log2n = 3'd4; seq_stage = 3'd2; cfg_inverse = 1'b0; out_ready = 1'b1;
        seq_start = 1'b1;
        step();
        seq_start = 1'b0;
        for (int c = 0; c < 30 && got < 4; c++) begin
            busy += seq_busy;
            if (stall && out_valid && !seen) begin
                seen = 1; hold = 3;
                h_tw = twiddle_out; h_k = out_k; h_last = out_last;
            end else if (hold > 0) begin
                total++;
                if (twiddle_out !== h_tw || out_k !== h_k || out_last !== h_last || out_valid !== 1'b1) begin
                    bad++;
                    $display("FAIL seq_hold got tw=%h k=%0d last=%b v=%b want tw=%h k=%0d last=%b v=1",
                             twiddle_out, out_k, out_last, out_valid, h_tw, h_k, h_last);
                end
                hold--;
            end
            out_ready = (hold == 0);
            #1;
            if (out_valid && out_ready) begin
                total++;
                if (twiddle_out !== ex[got] || out_k !== AW'(2 * got) || out_last !== (got == 3)) begin
                    bad++;
                    $display("FAIL seq_out i=%0d got tw=%h k=%0d last=%b want tw=%h k=%0d last=%b",
                             got, twiddle_out, out_k, out_last, ex[got], 2 * got, got == 3);
                end
                got++;
            end
            step();
        end
        total++;
        if (got != 4) begin
            bad++; $display("FAIL seq_count got %0d want 4", got);
        end
        if (!stall) begin
            total++;
            if (busy != 4) begin
                bad++; $display("FAIL seq_busy_cycles got %0d want 4", busy);
            end
        end
        out_ready = 1'b1;
        step();
        total++;
        if (out_valid !== 1'b0 || seq_busy !== 1'b0) begin
            bad++; $display("FAIL seq_done got v=%b busy=%b want 0 0", out_valid, seq_busy);
        end
    endtask

    task automatic test_errors();
        logic v, e;
        logic [7:0] tw;
        int vcount = 0;
        do_req(3, 6, 1'b0, v, tw, e);
        total++;
        if (v !== 1'b1 || tw !== 8'h00 || e !== 1'b1) begin
            bad++; $display("FAIL err_n6 got v=%b tw=%h err=%b want v=1 tw=00 err=1", v, tw, e);
        end
        total++;
        if (cfg_err !== 1'b0) begin
            bad++; $display("FAIL err_pulse_width got %b want 0", cfg_err);
        end
        do_req(1, 0, 1'b0, v, tw, e);
        total++;
        if (v !== 1'b1 || tw !== 8'h00 || e !== 1'b1) begin
            bad++; $display("FAIL err_n0 got v=%b tw=%h err=%b want v=1 tw=00 err=1", v, tw, e);
        end
        step();
        cfg_log2n = 3'd4; seq_stage = 3'd4; seq_start = 1'b1;
        step();
        seq_start = 1'b0;
        total++;
        if (cfg_err !== 1'b1 || seq_busy !== 1'b0) begin
            bad++; $display("FAIL err_stage got err=%b busy=%b want 1 0", cfg_err, seq_busy);
        end
        for (int c = 0; c < 4; c++) begin
            vcount += out_valid + seq_busy;
            step();
        end
        total++;
        if (vcount != 0) begin
            bad++; $display("FAIL err_stage_quiet got %0d activity cycles want 0", vcount);
        end
    endtask

    task automatic test_reset_midseq();
        cfg_log2n = 3'd4; seq_stage = 3'd2; out_ready = 1'b1; seq_start = 1'b1;
        step();
        seq_start = 1'b0;
        step(); step();
        rst = 1'b1;
        #1;
        total++;
        if (out_valid !== 1'b0 || seq_busy !== 1'b0 || twiddle_out !== 8'h00) begin
            bad++;
            $display("FAIL midseq_reset got v=%b busy=%b tw=%h want 0 0 00", out_valid, seq_busy, twiddle_out);
        end
        step();
        rst = 1'b0;
        #1;
        total++;
        if (req_ready !== 1'b1) begin
            bad++; $display("FAIL midseq_ready got %b want 1", req_ready);
        end
        for (int c = 0; c < 4; c++) begin
            step();
            total++;
            if (out_valid !== 1'b0 || seq_busy !== 1'b0) begin
                bad++; $display("FAIL midseq_aborted c=%0d got v=%b busy=%b want 0 0", c, out_valid, seq_busy);
            end
        end
    endtask

    task automatic test_random();
        exp_t q[$];
        exp_t e;
        bit   pend = 0, err_exp = 0;
        int   n, s, sh;
        for (int c = 0; c < 500; c++) begin
            total++;
            if (cfg_err !== err_exp) begin
                bad++; $display("FAIL rnd_err c=%0d got %b want %b", c, cfg_err, err_exp);
            end
            err_exp     = 0;
            out_ready   = ($urandom_range(0, 3) != 0);
            cfg_log2n   = LW'($urandom_range(0, 6));
            cfg_inverse = 1'($urandom_range(0, 1));
            req_k       = AW'($urandom);
            req_valid   = !pend && ($urandom_range(0, 2) != 0);
            seq_start   = !pend && ($urandom_range(0, 11) == 0);
            seq_stage   = LW'($urandom_range(0, 5));
            #1;
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL rnd_extra c=%0d got tw=%h k=%0d want no output", c, twiddle_out, out_k);
                end else begin
                    e = q.pop_front();
                    total++;
                    if (twiddle_out !== e.tw || out_k !== e.k || out_last !== e.last) begin
                        bad++;
                        $display("FAIL rnd_out c=%0d got tw=%h k=%0d last=%b want tw=%h k=%0d last=%b",
                                 c, twiddle_out, out_k, out_last, e.tw, e.k, e.last);
                    end
                end
                if (q.size() == 0) pend = 0;
            end
            n = int'(cfg_log2n);
            if (seq_start) begin
                s = int'(seq_stage);
                if (n >= 1 && n <= AW && s < n) begin
                    sh = n - s - 1;
                    for (int j = 0; j < (1 << s); j++) begin
                        e.k    = AW'(j << sh);
                        e.tw   = model_tw(j << sh, n, cfg_inverse);
                        e.last = (j == (1 << s) - 1);
                        q.push_back(e);
                    end
                    pend = 1;
                end else begin
                    err_exp = 1;
                end
            end else begin
                if (out_ready && !pend) begin
                    total++;
                    if (req_ready !== 1'b1) begin
                        bad++; $display("FAIL rnd_ready c=%0d got %b want 1", c, req_ready);
                    end
                end
                if (req_valid && req_ready) begin
                    e.k = req_k; e.tw = model_tw(int'(req_k), n, cfg_inverse); e.last = 1'b0;
                    q.push_back(e);
                    err_exp = !(n >= 1 && n <= AW);
                end
            end
            step();
        end
        req_valid = 1'b0; seq_start = 1'b0; out_ready = 1'b1;
        for (int c = 0; c < 40 && q.size() > 0; c++) begin
            total++;
            if (cfg_err !== err_exp) begin
                bad++; $display("FAIL rnd_drain_err got %b want %b", cfg_err, err_exp);
            end
            err_exp = 0;
            if (out_valid) begin
                e = q.pop_front();
                total++;
                if (twiddle_out !== e.tw || out_k !== e.k || out_last !== e.last) begin
                    bad++;
                    $display("FAIL rnd_drain got tw=%h k=%0d last=%b want tw=%h k=%0d last=%b",
                             twiddle_out, out_k, out_last, e.tw, e.k, e.last);
                end
            end
            step();
        end
        total++;
        if (q.size() != 0) begin
            bad++; $display("FAIL rnd_missing got %0d outstanding want 0", q.size());
        end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_small_n();
        test_sequence(1'b0);
        test_sequence(1'b1);
        test_errors();
        test_reset_midseq();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
